pipeline_ctrl_v2: RTL and testbench

- Parametrised pipeline hazard and redirect controller for the in-order core. Successor to the fixed 7-stage controller.
- Generalises the stall mask to STAGE_NUM stages, with one stall-request bit per stage.
- Adds vectored exception entry (EENTRY base plus a code-scaled offset), exception-return (ertn) redirect, multi-cycle registered flush, an ERA capture register, a stall watchdog and a stall performance counter.
- Sits beside the pipeline: collects requests from all stages and drives stall/flush to every pipeline register and redirect to the PC stage.

---
 rtl/pipeline_ctrl_v2.sv | 118 +++++++++++
 tb/tb_pipeline_ctrl_v2.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_v2.sv
// Pipeline hazard/redirect controller: per-stage stall mask, vectored exception
// entry, ertn redirect, multi-cycle flush, ERA capture, stall watchdog and perf counter.
module pipeline_ctrl_v2 #(
    parameter int unsigned STAGE_NUM    = 7,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned EXC_W        = 4,
    parameter int unsigned VEC_SHIFT    = 6,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned WDT_W        = 8,
    parameter int unsigned PERF_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [STAGE_NUM-1:0] stall_req_i,
    input  logic                 excp_valid_i,
    input  logic [EXC_W-1:0]     excp_code_i,
    input  logic [ADDR_W-1:0]    excp_pc_i,
    input  logic [ADDR_W-1:0]    eentry_i,
    input  logic                 ertn_i,
    output logic [STAGE_NUM-1:0] stall_o,
    output logic                 flush_o,
    output logic                 redirect_valid_o,
    output logic [ADDR_W-1:0]    new_pc_o,
    output logic [ADDR_W-1:0]    era_o,
    output logic                 stall_timeout_o,
    output logic [PERF_W-1:0]    stall_cnt_o
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t               state;
    logic [FC_W-1:0]      flush_cnt;
    logic [WDT_W-1:0]     wdt;
    logic [WDT_W-1:0]     wdt_nxt;
    logic [STAGE_NUM-1:0] mask;
    logic                 hit;
    logic                 stalled;
    logic [ADDR_W-1:0]    vec_pc;

    // Scanning from the top stage down, every stage at or below the highest requester stalls.
    always_comb begin
        hit  = 1'b0;
        mask = '0;
        for (int unsigned k = STAGE_NUM; k > 0; k--) begin
            hit       = hit | stall_req_i[k-1];
            mask[k-1] = hit;
        end
    end

    always_comb begin
        stall_o = '0;
        if (rst_n && (state == RUN) && !excp_valid_i && !ertn_i)
            stall_o = mask;
    end

    always_comb begin
        stalled = |stall_o;
        vec_pc  = eentry_i + (ADDR_W'(excp_code_i) << VEC_SHIFT);
        if (!stalled)
            wdt_nxt = '0;
        else if (wdt == '1)
            wdt_nxt = wdt;
        else
            wdt_nxt = wdt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= RUN;
            flush_cnt        <= '0;
            wdt              <= '0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            new_pc_o         <= '0;
            era_o            <= '0;
            stall_timeout_o  <= 1'b0;
            stall_cnt_o      <= '0;
        end else begin
            wdt <= wdt_nxt;
            if (wdt_nxt == '1)
                stall_timeout_o <= 1'b1;
            if (stalled && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + 1'b1;

            case (state)
                RUN: begin
                    if (excp_valid_i) begin
                        state            <= FLUSH;
                        flush_cnt        <= FC_W'(FLUSH_CYCLES - 1);
                        era_o            <= excp_pc_i;
                        new_pc_o         <= vec_pc;
                        redirect_valid_o <= 1'b1;
                        flush_o          <= 1'b1;
                    end else if (ertn_i) begin
                        state            <= FLUSH;
                        flush_cnt        <= FC_W'(FLUSH_CYCLES - 1);
                        new_pc_o         <= era_o;
                        redirect_valid_o <= 1'b1;
                        flush_o          <= 1'b1;
                    end
                end
                FLUSH: begin
                    redirect_valid_o <= 1'b0;
                    if (flush_cnt == '0) begin
                        state   <= RUN;
                        flush_o <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl_v2.sv
// Directed, table-driven bench for pipeline_ctrl_v2; a second instance with narrow
// watchdog/perf counters covers timeout and saturation.
module tb_pipeline_ctrl_v2;

    logic        clk;
    logic        rst_n;
    logic [6:0]  stall_req;
    logic        excp_valid;
    logic [3:0]  excp_code;
    logic [31:0] excp_pc;
    logic [31:0] eentry;
    logic        ertn;

    logic [6:0]  stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] new_pc;
    logic [31:0] era;
    logic        stall_timeout;
    logic [31:0] stall_cnt;

    logic [6:0]  stall_s;
    logic        flush_s;
    logic        redirect_valid_s;
    logic [31:0] new_pc_s;
    logic [31:0] era_s;
    logic        stall_timeout_s;
    logic [3:0]  stall_cnt_s;

    int checks = 0;
    int errors = 0;

    pipeline_ctrl_v2 dut (
        .clk(clk), .rst_n(rst_n), .stall_req_i(stall_req), .excp_valid_i(excp_valid),
        .excp_code_i(excp_code), .excp_pc_i(excp_pc), .eentry_i(eentry), .ertn_i(ertn),
        .stall_o(stall), .flush_o(flush), .redirect_valid_o(redirect_valid),
        .new_pc_o(new_pc), .era_o(era), .stall_timeout_o(stall_timeout),
        .stall_cnt_o(stall_cnt)
    );

    pipeline_ctrl_v2 #(.WDT_W(4), .PERF_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .stall_req_i(stall_req), .excp_valid_i(excp_valid),
        .excp_code_i(excp_code), .excp_pc_i(excp_pc), .eentry_i(eentry), .ertn_i(ertn),
        .stall_o(stall_s), .flush_o(flush_s), .redirect_valid_o(redirect_valid_s),
        .new_pc_o(new_pc_s), .era_o(era_s), .stall_timeout_o(stall_timeout_s),
        .stall_cnt_o(stall_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    typedef struct {
        logic        rst_n;
        logic [6:0]  req;
        logic        ev;
        logic        er;
        logic [3:0]  code;
        logic [31:0] pc;
        logic [31:0] ee;
        logic [6:0]  e_stall;
        logic        e_flush;
        logic        e_rv;
        logic [31:0] e_npc;
        logic [31:0] e_era;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [6:0] req, input logic ev, input logic er,
                       input logic [3:0] code, input logic [31:0] pc, input logic [31:0] ee,
                       input logic [6:0] es, input logic ef, input logic erv,
                       input logic [31:0] enpc, input logic [31:0] eera, input logic [31:0] ecnt);
        vec_t v;
        v.rst_n = r; v.req = req; v.ev = ev; v.er = er; v.code = code; v.pc = pc; v.ee = ee;
        v.e_stall = es; v.e_flush = ef; v.e_rv = erv; v.e_npc = enpc; v.e_era = eera;
        v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    localparam logic [31:0] EE = 32'h1C000000;
    localparam logic [31:0] PC = 32'h1C000040;

    initial begin
        // rst req ev er code pc ee | stall flush rv new_pc era cnt
        add(0, 7'h7F, 1, 0, 4'h3, PC, EE,                 7'h00, 0, 0, 32'h0, 32'h0, 0);
        add(0, 7'h7F, 1, 0, 4'h3, PC, EE,                 7'h00, 0, 0, 32'h0, 32'h0, 0);
        add(1, 7'h7F, 0, 0, 4'h3, PC, EE,                 7'h7F, 0, 0, 32'h0, 32'h0, 1);
        add(1, 7'h08, 0, 0, 4'h3, PC, EE,                 7'h0F, 0, 0, 32'h0, 32'h0, 2);
        add(1, 7'h18, 0, 0, 4'h3, PC, EE,                 7'h1F, 0, 0, 32'h0, 32'h0, 3);
        add(1, 7'h00, 0, 0, 4'h3, PC, EE,                 7'h00, 0, 0, 32'h0, 32'h0, 3);
        add(1, 7'h01, 0, 0, 4'h3, PC, EE,                 7'h01, 0, 0, 32'h0, 32'h0, 4);
        add(1, 7'h40, 0, 0, 4'h3, PC, EE,                 7'h7F, 0, 0, 32'h0, 32'h0, 5);
        add(1, 7'h7F, 1, 0, 4'h3, PC, EE,                 7'h00, 1, 1, 32'h1C0000C0, PC, 5);
        add(1, 7'h7F, 1, 0, 4'h5, 32'h1C000100, EE,       7'h00, 1, 0, 32'h1C0000C0, PC, 5);
        add(1, 7'h00, 0, 1, 4'h5, 32'h1C000100, EE,       7'h00, 0, 0, 32'h1C0000C0, PC, 5);
        add(1, 7'h02, 0, 0, 4'h0, 32'h0, EE,              7'h03, 0, 0, 32'h1C0000C0, PC, 6);
        add(1, 7'h00, 1, 1, 4'h2, PC, EE,                 7'h00, 1, 1, 32'h1C000080, PC, 6);
        add(1, 7'h00, 0, 0, 4'h0, 32'h0, EE,              7'h00, 1, 0, 32'h1C000080, PC, 6);
        add(1, 7'h00, 0, 0, 4'h0, 32'h0, EE,              7'h00, 0, 0, 32'h1C000080, PC, 6);
        add(1, 7'h00, 0, 1, 4'h0, 32'h0, EE,              7'h00, 1, 1, PC, PC, 6);
        add(1, 7'h00, 0, 0, 4'h0, 32'h0, EE,              7'h00, 1, 0, PC, PC, 6);
        add(1, 7'h00, 0, 0, 4'h0, 32'h0, EE,              7'h00, 0, 0, PC, PC, 6);
        add(1, 7'h00, 1, 0, 4'hF, 32'h12345678, 32'hFFFFFFF0, 7'h00, 1, 1, 32'h000003B0, 32'h12345678, 6);
        add(1, 7'h00, 0, 0, 4'h0, 32'h0, EE,              7'h00, 1, 0, 32'h000003B0, 32'h12345678, 6);
        add(1, 7'h00, 0, 0, 4'h0, 32'h0, EE,              7'h00, 0, 0, 32'h000003B0, 32'h12345678, 6);
        add(1, 7'h04, 0, 0, 4'h0, 32'h0, EE,              7'h07, 0, 0, 32'h000003B0, 32'h12345678, 7);
        add(1, 7'h04, 0, 1, 4'h0, 32'h0, EE,              7'h00, 1, 1, 32'h12345678, 32'h12345678, 7);
        add(0, 7'h04, 0, 0, 4'h0, 32'h0, EE,              7'h00, 0, 0, 32'h0, 32'h0, 0);
        add(1, 7'h00, 0, 0, 4'h0, 32'h0, EE,              7'h00, 0, 0, 32'h0, 32'h0, 0);
        add(1, 7'h10, 0, 0, 4'h0, 32'h0, EE,              7'h1F, 0, 0, 32'h0, 32'h0, 1);

        rst_n = 1'b0; stall_req = '0; excp_valid = 1'b0; excp_code = '0;
        excp_pc = '0; eentry = '0; ertn = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; stall_req = vecs[i].req; excp_valid = vecs[i].ev;
            ertn = vecs[i].er; excp_code = vecs[i].code; excp_pc = vecs[i].pc;
            eentry = vecs[i].ee;
            @(negedge clk);
            check($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].e_stall));
            @(posedge clk);
            #1;
            check($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].e_flush));
            check($sformatf("v%0d redirect", i), 32'(redirect_valid), 32'(vecs[i].e_rv));
            check($sformatf("v%0d new_pc", i), new_pc, vecs[i].e_npc);
            check($sformatf("v%0d era", i), era, vecs[i].e_era);
            check($sformatf("v%0d stall_cnt", i), stall_cnt, vecs[i].e_cnt);
        end

        // Watchdog / saturation on the narrow instance
        rst_n = 1'b0; stall_req = '0; excp_valid = 1'b0; ertn = 1'b0;
        @(posedge clk);
        #1;
        check("wdt reset timeout", 32'(stall_timeout_s), 32'd0);
        check("wdt reset cnt", 32'(stall_cnt_s), 32'd0);
        rst_n = 1'b1; stall_req = 7'h04;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("wdt c%0d timeout", c), 32'(stall_timeout_s), (c >= 15) ? 32'd1 : 32'd0);
            check($sformatf("wdt c%0d cnt", c), 32'(stall_cnt_s), (c >= 15) ? 32'd15 : 32'(c));
        end
        check("wdt wide no timeout", 32'(stall_timeout), 32'd0);
        check("wdt wide cnt", stall_cnt, 32'd18);
        stall_req = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("wdt sticky c%0d", c), 32'(stall_timeout_s), 32'd1);
            check($sformatf("wdt cnt hold c%0d", c), 32'(stall_cnt_s), 32'd15);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("wdt cleared by reset", 32'(stall_timeout_s), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
